control_fsm_mc: RTL
===================

Name: control_fsm_mc

Overview:
- Multicycle main control state machine for the kianV rv32i datapath.
- Sits directly upstream of alu_decoder: it sequences fetch/decode/execute/writeback and drives ALUOp plus all datapath mux selects and write enables.
- Memory is accessed through a valid/ready handshake shared by instruction fetch and load/store.

Parameters:
- STATE_WIDTH, 4, width of the state register and of the `state` debug output.
- ALU_OP_W, `ALU_OP_WIDTH, width of ALUOp; encodings come from riscv_defines.vh.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- resetn  in  1  reset is synchronous and active-low.
- op  in  7  opcode field of the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_valid  out  1  memory access request.
- AdrSrc  out  1  address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  store strobe, valid only with mem_valid.
- IRWrite  out  1  capture instruction and OldPC.
- PCUpdate  out  1  unconditional PC write.
- Branch  out  1  conditional PC write, qualified by the ALU branch flag.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  0 = PC, 1 = OldPC, 2 = rs1.
- ALUSrcB  out  2  0 = rs2, 1 = imm, 2 = const 4.
- ResultSrc  out  2  0 = ALUOut, 1 = mem data, 2 = ALUResult.
- ALUOp  out  ALU_OP_W  to alu_decoder.
- state  out  STATE_WIDTH  current state, for debug and trace.

Behaviour:
- Outputs are Moore, decoded from state. Exception: IRWrite and PCUpdate in FETCH are gated by mem_ready.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALR_PC=12, LUI=13, AUIPC=14. Code 15 goes to FETCH next cycle with all strobes 0.
- Reset: while resetn=0 at a clock edge, state<=FETCH. All outputs are forced to 0 while resetn is low, including mem_valid, with ALUOp=`ALU_OP_ADD. Reset mid-access abandons the access.
- Defaults in every state: all strobes 0, selects 0, ALUOp=`ALU_OP_ADD.
- FETCH:
  - Drives mem_valid=1, AdrSrc=0, SrcA=PC, SrcB=4, ResultSrc=2.
  - Holds until mem_ready=1. That cycle also asserts IRWrite=1 and PCUpdate=1, then goes to DECODE.
- DECODE: SrcA=OldPC, SrcB=imm, ADD (branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other opcode (fence/system included) -> FETCH, as a NOP.
- MEMADR: SrcA=rs1, SrcB=imm, ADD. Goes to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_valid=1, AdrSrc=1; holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc=1, RegWrite=1 -> FETCH.
- MEMWRITE: mem_valid=1, AdrSrc=1, MemWrite=1; holds until mem_ready, then FETCH.
- EXECUTER: SrcA=rs1, SrcB=rs2, ALUOp=`ALU_OP_ARITH_LOGIC -> ALUWB.
- EXECUTEI: same as EXECUTER but SrcB=imm -> ALUWB.
- ALUWB: ResultSrc=0, RegWrite=1 -> FETCH.
- BRANCH: SrcA=rs1, SrcB=rs2, ALUOp=`ALU_OP_BRANCH, ResultSrc=0, Branch=1 -> FETCH.
- JAL: SrcA=OldPC, SrcB=4, ADD, ResultSrc=0, PCUpdate=1 -> ALUWB (link = OldPC+4).
- JALR: SrcA=rs1, SrcB=imm, ADD -> JALR_PC.
- JALR_PC: ResultSrc=0, PCUpdate=1, SrcA=OldPC, SrcB=4, ADD -> ALUWB.
- LUI: SrcB=imm, ALUOp=`ALU_OP_LUI -> ALUWB.
- AUIPC: SrcA=OldPC, SrcB=imm, ALUOp=`ALU_OP_AUIPC -> ALUWB.
- Handshake rules:
  - mem_valid, AdrSrc and MemWrite stay stable until the mem_ready cycle.
  - mem_ready is ignored while mem_valid=0.
  - mem_ready asserted in the same cycle as the request completes with zero wait states.

Test Plan:
- Reset: resetn=0 for 2 cycles with mem_ready=1 -> state=0, mem_valid=0, all strobes 0. First cycle after release: mem_valid=1, AdrSrc=0.
- addi (op=0010011), mem_ready=1 -> states 0,1,7,8,0. IRWrite/PCUpdate high in cycle 0; ALUOp=ARITH_LOGIC in state 7; RegWrite high in state 8.
- lw (op=0000011), 2 wait states on data access -> states 0,1,2,3,3,3,4,0. mem_valid=1 and AdrSrc=1 held for all three MEMREAD cycles; RegWrite with ResultSrc=1 in state 4.
- sw (op=0100011), fetch with 3 wait states -> FETCH held 4 cycles with IRWrite=0 until mem_ready. Then 1,2,5 with MemWrite=1, then 0.
- jalr (op=1100111) -> states 0,1,11,12,8,0. PCUpdate=1 in state 12 with ResultSrc=0; RegWrite in state 8. Also beq -> Branch=1 and ALUOp=BRANCH in state 9.
- Illegal op=0000000 -> DECODE -> FETCH, no RegWrite/MemWrite. resetn=0 during MEMWRITE wait -> next cycle state=0 and mem_valid=0.

Source files
------------

// File: rtl/control_fsm_mc.sv
// Multicycle main control FSM for the kianV rv32i datapath.
// Sequences fetch/decode/execute/writeback, drives ALUOp for alu_decoder
// and every datapath mux select and write enable. Memory accesses (fetch
// and load/store) share one valid/ready handshake.

// Fallback ALU operation encodings, used only when riscv_defines.vh has not
// already been read ahead of this file.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 3
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'b000
`endif
`ifndef ALU_OP_ARITH_LOGIC
`define ALU_OP_ARITH_LOGIC 3'b010
`endif
`ifndef ALU_OP_BRANCH
`define ALU_OP_BRANCH 3'b011
`endif
`ifndef ALU_OP_LUI
`define ALU_OP_LUI 3'b100
`endif
`ifndef ALU_OP_AUIPC
`define ALU_OP_AUIPC 3'b101
`endif

module control_fsm_mc #(
  parameter int STATE_WIDTH = 4,
  parameter int ALU_OP_W    = `ALU_OP_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [6:0]             op,
  input  logic                   mem_ready,
  output logic                   mem_valid,
  output logic                   AdrSrc,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   PCUpdate,
  output logic                   Branch,
  output logic                   RegWrite,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ResultSrc,
  output logic [ALU_OP_W-1:0]    ALUOp,
  output logic [STATE_WIDTH-1:0] state
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH    = STATE_WIDTH'(0),
    DECODE   = STATE_WIDTH'(1),
    MEMADR   = STATE_WIDTH'(2),
    MEMREAD  = STATE_WIDTH'(3),
    MEMWB    = STATE_WIDTH'(4),
    MEMWRITE = STATE_WIDTH'(5),
    EXECUTER = STATE_WIDTH'(6),
    EXECUTEI = STATE_WIDTH'(7),
    ALUWB    = STATE_WIDTH'(8),
    BRANCH   = STATE_WIDTH'(9),
    JAL      = STATE_WIDTH'(10),
    JALR     = STATE_WIDTH'(11),
    JALR_PC  = STATE_WIDTH'(12),
    LUI      = STATE_WIDTH'(13),
    AUIPC    = STATE_WIDTH'(14)
  } state_t;

  // rv32i major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Mux select encodings
  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_OLDPC  = 2'd1;
  localparam logic [1:0] SRCA_RS1    = 2'd2;
  localparam logic [1:0] SRCB_RS2    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_FOUR   = 2'd2;
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALURES  = 2'd2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(`ALU_OP_ADD);
  localparam logic [ALU_OP_W-1:0] ALU_AL    = ALU_OP_W'(`ALU_OP_ARITH_LOGIC);
  localparam logic [ALU_OP_W-1:0] ALU_BR    = ALU_OP_W'(`ALU_OP_BRANCH);
  localparam logic [ALU_OP_W-1:0] ALU_LUI   = ALU_OP_W'(`ALU_OP_LUI);
  localparam logic [ALU_OP_W-1:0] ALU_AUIPC = ALU_OP_W'(`ALU_OP_AUIPC);

  state_t state_q;

  // State register and next-state sequencing (synchronous active-low reset)
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:    if (mem_ready) state_q <= DECODE;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state_q <= MEMADR;
            OP_R:              state_q <= EXECUTER;
            OP_I:              state_q <= EXECUTEI;
            OP_BRANCH:         state_q <= BRANCH;
            OP_JAL:            state_q <= JAL;
            OP_JALR:           state_q <= JALR;
            OP_LUI:            state_q <= LUI;
            OP_AUIPC:          state_q <= AUIPC;
            default:           state_q <= FETCH;  // fence/system/illegal: NOP
          endcase
        end
        MEMADR:   state_q <= (op == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state_q <= MEMWB;
        MEMWB:    state_q <= FETCH;
        MEMWRITE: if (mem_ready) state_q <= FETCH;
        EXECUTER: state_q <= ALUWB;
        EXECUTEI: state_q <= ALUWB;
        ALUWB:    state_q <= FETCH;
        BRANCH:   state_q <= FETCH;
        JAL:      state_q <= ALUWB;
        JALR:     state_q <= JALR_PC;
        JALR_PC:  state_q <= ALUWB;
        LUI:      state_q <= ALUWB;
        AUIPC:    state_q <= ALUWB;
        default:  state_q <= FETCH;  // unused code recovers immediately
      endcase
    end
  end

  // Moore output decode; everything is held at zero while resetn is low,
  // which also drops any in-flight memory request.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    mem_valid = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ALUOp     = ALU_ADD;
    if (resetn) begin
      case (state_q)
        FETCH: begin
          mem_valid = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
          IRWrite   = mem_ready;
          PCUpdate  = mem_ready;
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        MEMREAD: begin
          mem_valid = 1'b1;
          AdrSrc    = 1'b1;
        end
        MEMWB: begin
          ResultSrc = RES_MEMDATA;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          mem_valid = 1'b1;
          AdrSrc    = 1'b1;
          MemWrite  = 1'b1;
        end
        EXECUTER: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_AL;
        end
        EXECUTEI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_AL;
        end
        ALUWB: begin
          ResultSrc = RES_ALUOUT;
          RegWrite  = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_BR;
          Branch  = 1'b1;
        end
        JAL, JALR_PC: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCUpdate = 1'b1;
        end
        JALR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        LUI: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_LUI;
        end
        AUIPC: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_AUIPC;
        end
        default: ;
      endcase
    end
  end

  // Debug/trace view of the state register, zero while in reset
  assign state = resetn ? state_q : '0;

endmodule
